datain_rr_arbiter: RTL and testbench

//  Round-robin scheduler sharing one datain buffer write port among NREQ flit sources.

---
 rtl/datain_rr_arbiter_pkg.sv | 23 ++
 rtl/datain_rr_arbiter_if.sv | 28 ++
 rtl/datain_rr_arbiter_rr_pick.sv | 31 +++
 rtl/datain_rr_arbiter.sv | 111 +++++++++++
 tb/tb_datain_rr_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/datain_rr_arbiter_pkg.sv
// Shared definitions for the datain round-robin arbiter: flit layout and FSM state encoding.
package datain_rr_arbiter_pkg;

  localparam int DEF_FLIT_W  = 20;
  localparam int PAYLOAD_MSB = 19;
  localparam int PAYLOAD_LSB = 4;
  localparam int HDR_MSB     = 3;
  localparam int HDR_LSB     = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } arb_state_e;

  function automatic logic [HDR_MSB-HDR_LSB:0] flit_hdr(input logic [DEF_FLIT_W-1:0] flit);
    return flit[HDR_MSB:HDR_LSB];
  endfunction

  function automatic logic [PAYLOAD_MSB-PAYLOAD_LSB:0] flit_payload(input logic [DEF_FLIT_W-1:0] flit);
    return flit[PAYLOAD_MSB:PAYLOAD_LSB];
  endfunction

endpackage

// File: rtl/datain_rr_arbiter_if.sv
// Bundle between the flit sources, the arbiter and the datain buffer write port.
interface datain_rr_arbiter_if
  import datain_rr_arbiter_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int FLIT_W = DEF_FLIT_W
);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*FLIT_W-1:0] req_flit;
  logic [NREQ-1:0]        req_ready;
  logic                   out_valid;
  logic [FLIT_W-1:0]      out_flit;
  logic                   out_ready;
  logic                   buf_state;

  // master is the environment (sources plus buffer), slave is the arbiter itself
  modport master (
    output req_valid, req_flit, out_ready, buf_state,
    input  req_ready, out_valid, out_flit
  );

  modport slave (
    input  req_valid, req_flit, out_ready, buf_state,
    output req_ready, out_valid, out_flit
  );

endinterface

// File: rtl/datain_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request scanning ptr+1, ptr+2, ... modulo NREQ.
module datain_rr_arbiter_rr_pick #(
  parameter  int NREQ  = 4,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // The last granted source (ptr) is visited last, giving it the lowest priority
  always_comb begin
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand     = (int'(ptr) + k) % NREQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/datain_rr_arbiter.sv
// Round-robin scheduler sharing one datain buffer write port among NREQ sources,
// with bursts of up to BURST flits per grant and a single output register stage.
module datain_rr_arbiter
  import datain_rr_arbiter_pkg::*;
#(
  parameter  int NREQ         = 4,
  parameter  int FLIT_W       = DEF_FLIT_W,
  parameter  int BURST        = 4,
  parameter  int CNT_W        = 16,
  parameter  bit STOP_ON_FULL = 1'b1,
  localparam int IDX_W        = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  datain_rr_arbiter_if.slave   bus,
  output logic [IDX_W-1:0]     grant_id,
  output logic                 busy,
  output logic [CNT_W-1:0]     flit_count
);

  arb_state_e        state;
  arb_state_e        state_nxt;
  logic [7:0]        burst_cnt;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic              g_valid;
  logic              g_ready;
  logic [FLIT_W-1:0] g_flit;
  logic              accept;
  logic              fire;
  logic              grant_now;
  logic              burst_end;

  datain_rr_arbiter_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Ready to the granted source whenever the output register is empty or draining this cycle
  always_comb begin
    g_valid       = bus.req_valid[grant_id];
    g_flit        = bus.req_flit[int'(grant_id)*FLIT_W +: FLIT_W];
    g_ready       = !bus.out_valid || bus.out_ready;
    fire          = bus.out_valid && bus.out_ready;
    bus.req_ready = '0;
    accept        = 1'b0;
    grant_now     = 1'b0;
    burst_end     = 1'b0;
    state_nxt     = state;
    case (state)
      IDLE: begin
        grant_now = pick_found && !(STOP_ON_FULL && bus.buf_state);
        if (grant_now) state_nxt = SERVE;
      end
      SERVE: begin
        bus.req_ready[grant_id] = g_ready;
        accept    = g_valid && g_ready;
        burst_end = (accept && (burst_cnt == 8'(BURST-1))) || !g_valid;
        if (burst_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // ptr starts at NREQ-1 so that source 0 wins the very first scan
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_id  <= '0;
      ptr       <= IDX_W'(NREQ-1);
      burst_cnt <= '0;
    end else begin
      if (grant_now) begin
        grant_id  <= pick_idx;
        burst_cnt <= '0;
      end else if (accept) begin
        burst_cnt <= burst_cnt + 8'd1;
      end
      if (burst_end) ptr <= grant_id;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.out_valid <= 1'b0;
      bus.out_flit  <= '0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_flit  <= g_flit;
    end else if (fire) begin
      bus.out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          flit_count <= '0;
    else if (fire && (flit_count != '1)) flit_count <= flit_count + 1'b1;
  end

  assign busy = (state == SERVE);

endmodule

// File: tb/tb_datain_rr_arbiter.sv
// Directed and randomized bench for datain_rr_arbiter against a cycle-level
// reference model plus a per-source ordering scoreboard.
module tb_datain_rr_arbiter;
  import datain_rr_arbiter_pkg::*;

  localparam int NREQ    = 4;
  localparam int FW      = DEF_FLIT_W;
  localparam int BURST   = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       grant_id;
  logic             busy;
  logic [CNT_W-1:0] flit_count;

  datain_rr_arbiter_if #(.NREQ(NREQ), .FLIT_W(FW)) bus ();

  datain_rr_arbiter #(
    .NREQ(NREQ), .FLIT_W(FW), .BURST(BURST), .CNT_W(CNT_W), .STOP_ON_FULL(1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .grant_id   (grant_id),
    .busy       (busy),
    .flit_count (flit_count)
  );

  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_err = 0;
  logic [FW-1:0] srcq [NREQ][$];
  int            push_seq [NREQ];
  int            del_seq  [NREQ];
  logic [NREQ-1:0] en;
  logic          ordy;
  logic          bst;
  int            grants [$];
  logic          prev_busy;

  // Reference model: what the arbiter should be doing, as plain variables
  bit            m_serve;
  int            m_g;
  int            m_n;
  int            m_ptr;
  bit            m_ov;
  logic [FW-1:0] m_of;
  int            m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_serve = 0; m_g = 0; m_n = 0; m_ptr = NREQ - 1; m_ov = 0; m_of = '0; m_cnt = 0;
  endtask

  function automatic logic [NREQ-1:0] model_ready(input logic o_rdy);
    logic [NREQ-1:0] r;
    r = '0;
    if (m_serve) r[m_g] = !m_ov || o_rdy;
    return r;
  endfunction

  task automatic model_edge(input logic [NREQ-1:0] v, input logic [NREQ*FW-1:0] fl,
                            input logic o_rdy, input logic b_st);
    logic [NREQ-1:0] rdy;
    bit fire, take, picked;
    int s;
    rdy  = model_ready(o_rdy);
    fire = m_ov && o_rdy;
    if (fire && m_cnt < CNT_MAX) m_cnt++;
    if (!m_serve) begin
      if (fire) m_ov = 0;
      if (v != '0 && !b_st) begin
        picked = 0;
        for (int off = 1; off <= NREQ; off++) begin
          s = (m_ptr + off) % NREQ;
          if (!picked && v[s]) begin
            picked = 1; m_g = s;
          end
        end
        m_n = 0; m_serve = 1;
      end
    end else begin
      take = v[m_g] && rdy[m_g];
      if (take) begin
        m_of = fl[m_g*FW +: FW]; m_ov = 1; m_n++;
      end else if (fire) begin
        m_ov = 0;
      end
      if ((take && m_n == BURST) || !v[m_g]) begin
        m_serve = 0; m_ptr = m_g;
      end
    end
  endtask

  task automatic push(input int src, input int n);
    for (int k = 0; k < n; k++) begin
      srcq[src].push_back({16'(push_seq[src]), 4'(src)});
      push_seq[src]++;
    end
  endtask

  // Each source must come out in its own push order, nothing lost or repeated
  task automatic score(input logic [FW-1:0] f);
    int s;
    s = int'(flit_hdr(f));
    check("src_hdr", 32'(s < NREQ), 32'd1);
    if (s < NREQ) begin
      check("src_seq", 32'(flit_payload(f)), 32'(16'(del_seq[s])));
      del_seq[s]++;
    end
  endtask

  task automatic apply_stimulus();
    logic [NREQ-1:0] v;
    for (int i = 0; i < NREQ; i++) begin
      v[i] = en[i] && (srcq[i].size() > 0);
      bus.req_flit[i*FW +: FW] = (srcq[i].size() > 0) ? srcq[i][0] : '0;
    end
    bus.req_valid = v;
    bus.out_ready = ordy;
    bus.buf_state = bst;
  endtask

  task automatic check_output();
    check("busy",       32'(busy),          32'(m_serve));
    check("grant_id",   32'(grant_id),      32'(m_g));
    check("out_valid",  32'(bus.out_valid), 32'(m_ov));
    check("out_flit",   32'(bus.out_flit),  32'(m_of));
    check("flit_count", 32'(flit_count),    32'(m_cnt));
  endtask

  task automatic step();
    logic [NREQ-1:0]    v, acc;
    logic [NREQ*FW-1:0] fl;
    logic               o_rdy, b_st;
    apply_stimulus();
    #2;
    v = bus.req_valid; fl = bus.req_flit; o_rdy = bus.out_ready; b_st = bus.buf_state;
    check("req_ready", 32'(bus.req_ready), 32'(model_ready(o_rdy)));
    acc = v & bus.req_ready;
    if (bus.out_valid && bus.out_ready) score(bus.out_flit);
    @(posedge clk);
    for (int i = 0; i < NREQ; i++) if (acc[i]) void'(srcq[i].pop_front());
    model_edge(v, fl, o_rdy, b_st);
    @(negedge clk);
    check_output();
    if (busy && !prev_busy) grants.push_back(int'(grant_id));
    prev_busy = busy;
  endtask

  // Asserts reset between edges and checks that everything clears immediately
  task automatic do_reset();
    rst = 1'b0;
    en = '1; ordy = 1'b1; bst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      srcq[i].delete();
      del_seq[i] = push_seq[i];
    end
    bus.req_valid = '0; bus.req_flit = '0; bus.out_ready = 1'b1; bus.buf_state = 1'b0;
    model_reset();
    grants.delete();
    prev_busy = 1'b0;
    #1;
    check("rst_out_valid",  32'(bus.out_valid),  32'd0);
    check("rst_out_flit",   32'(bus.out_flit),   32'd0);
    check("rst_req_ready",  32'(bus.req_ready),  32'd0);
    check("rst_grant_id",   32'(grant_id),       32'd0);
    check("rst_busy",       32'(busy),           32'd0);
    check("rst_flit_count", 32'(flit_count),     32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int            exp_order [5];
    logic [FW-1:0] held;
    int            start_del;

    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NREQ; i++) begin
      push_seq[i] = 0;
      del_seq[i]  = 0;
    end
    do_reset();

    // All sources continuously valid: full bursts rotating 0,1,2,3,0
    for (int i = 0; i < NREQ; i++) push(i, 12);
    repeat (26) step();
    for (int k = 0; k < 5; k++)
      check($sformatf("grant_order%0d", k),
            32'((grants.size() > k) ? grants[k] : 255), 32'(exp_order[k]));

    // Reset in the middle of a burst, then source 0 must win first
    repeat (2) step();
    check("pre_reset_busy", 32'(busy), 32'd1);
    do_reset();
    for (int i = 0; i < NREQ; i++) push(i, 2);
    repeat (3) step();
    check("first_after_reset", 32'((grants.size() > 0) ? grants[0] : 255), 32'd0);

    // Lone source 2 runs dry after 3 flits; scan then resumes from 3
    do_reset();
    push(2, 3);
    repeat (8) step();
    check("dry_busy",  32'(busy),     32'd0);
    check("dry_grant", 32'(grant_id), 32'd2);
    check("dry_count", 32'(del_seq[2]), 32'(push_seq[2]));
    push(1, 1);
    push(3, 1);
    repeat (3) step();
    check("after_dry_grant", 32'((grants.size() > 1) ? grants[1] : 255), 32'd3);
    repeat (6) step();

    // Sink stalls for 5 cycles mid-burst
    do_reset();
    push(1, 6);
    repeat (3) step();
    check("stall_pre_valid", 32'(bus.out_valid), 32'd1);
    held = bus.out_flit;
    ordy = 1'b0;
    repeat (5) begin
      step();
      check("stall_flit", 32'(bus.out_flit), 32'(held));
    end
    ordy = 1'b1;
    repeat (12) step();
    check("stall_delivered", 32'(del_seq[1]), 32'(push_seq[1]));

    // Buffer full mid-burst: burst completes, no further grant
    do_reset();
    push(0, 4);
    push(1, 4);
    repeat (2) step();
    bst = 1'b1;
    repeat (10) step();
    check("full_busy",      32'(busy),             32'd0);
    check("full_src1_wait", 32'(srcq[1].size()),   32'd4);
    check("full_src0_done", 32'(del_seq[0]),       32'(push_seq[0]));
    bst = 1'b0;
    repeat (12) step();

    // Saturating delivered-flit counter
    do_reset();
    start_del = del_seq[0];
    push(0, 20);
    repeat (40) step();
    check("cnt_saturated", 32'(flit_count), 32'(CNT_MAX));
    check("cnt_delivered", 32'(del_seq[0] - start_del), 32'd20);

    // Randomized traffic with stalls and occasional full flag
    do_reset();
    repeat (600) begin
      for (int i = 0; i < NREQ; i++) en[i] = ($urandom_range(0, 7) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      bst  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 2) == 0) push($urandom_range(0, NREQ-1), $urandom_range(1, 3));
      step();
    end
    en = '1; ordy = 1'b1; bst = 1'b0;
    repeat (200) step();
    for (int i = 0; i < NREQ; i++)
      check($sformatf("drain_src%0d", i), 32'(del_seq[i]), 32'(push_seq[i]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
